// File: rtl/note_synth_if.sv
// Note-command and codec-write bundle for note_synth.
// slave = generator side, master = command source / codec side.
interface note_synth_if;
  logic        note_valid;
  logic [3:0]  note_code;
  logic [7:0]  note_dur;
  logic        note_ready;
  logic        busy;
  logic        write_ready;
  logic        write;
  logic [23:0] writedata_left;
  logic [23:0] writedata_right;

  modport slave (
    input  note_valid, note_code, note_dur, write_ready,
    output note_ready, busy, write, writedata_left, writedata_right
  );

  modport master (
    output note_valid, note_code, note_dur, write_ready,
    input  note_ready, busy, write, writedata_left, writedata_right
  );
endinterface

// File: rtl/note_synth.sv
// Square-wave note generator feeding the audio codec DAC write port.
// One note command at a time: tone for the requested duration, then a silence gap.
//
// state  | meaning
// S_IDLE | silent, waiting for a note command
// S_PLAY | emitting square-wave (or rest) samples, dur_cnt counting down
// S_GAP  | emitting silence, gap_cnt counting down
module note_synth #(
  parameter logic [23:0] AMPL          = 24'h100000,
  parameter int          GAP_SAMPLES   = 480,
  parameter int          DUR_UNIT_LOG2 = 8
) (
  input  logic        CLOCK_50,
  input  logic        reset,
  note_synth_if.slave bus
);

  localparam int          DUR_W    = 8 + DUR_UNIT_LOG2;
  localparam int          GAP_W    = $clog2(GAP_SAMPLES + 1);
  localparam logic [23:0] AMPL_NEG = ~AMPL + 24'd1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_PLAY = 2'd1,
    S_GAP  = 2'd2
  } state_t;

  state_t             r_state;
  logic [23:0]        r_sample;
  logic [6:0]         r_phase;
  logic [6:0]         r_half;
  logic               r_pol;
  logic [DUR_W-1:0]   r_dur;
  logic [GAP_W-1:0]   r_gap;
  logic               r_note_ready;
  logic               r_busy;

  logic               w_accept;
  logic               w_cmd_accept;
  logic [6:0]         w_half_in;
  logic [7:0]         w_dur_units;
  logic [DUR_W-1:0]   w_dur_load;
  logic               w_wrap;
  logic               w_pol_next;

  // Half-period in samples for C4..B4; zero marks a rest code.
  function automatic logic [6:0] half_period(input logic [3:0] code);
    case (code)
      4'd1:    return 7'd92;
      4'd2:    return 7'd87;
      4'd3:    return 7'd82;
      4'd4:    return 7'd77;
      4'd5:    return 7'd73;
      4'd6:    return 7'd69;
      4'd7:    return 7'd65;
      4'd8:    return 7'd61;
      4'd9:    return 7'd58;
      4'd10:   return 7'd55;
      4'd11:   return 7'd51;
      4'd12:   return 7'd49;
      default: return 7'd0;
    endcase
  endfunction

  // The codec FIFO is fed whenever it has room; nothing is strobed during reset.
  assign bus.write           = bus.write_ready & reset;
  assign bus.writedata_left  = r_sample;
  assign bus.writedata_right = r_sample;
  assign bus.note_ready      = r_note_ready;
  assign bus.busy            = r_busy;

  assign w_accept     = bus.write & bus.write_ready;
  assign w_cmd_accept = bus.note_valid & r_note_ready;
  assign w_half_in    = half_period(bus.note_code);
  assign w_dur_units  = (bus.note_dur == 8'd0) ? 8'd1 : bus.note_dur;
  assign w_dur_load   = {w_dur_units, {DUR_UNIT_LOG2{1'b0}}};

  // Rests never toggle polarity, so the phase counter is free to wrap harmlessly.
  assign w_wrap     = (r_half != 7'd0) && (r_phase == r_half - 7'd1);
  assign w_pol_next = r_pol ^ w_wrap;

  always_ff @(posedge CLOCK_50 or negedge reset) begin
    if (!reset) begin
      r_state      <= S_IDLE;
      r_sample     <= '0;
      r_phase      <= '0;
      r_half       <= '0;
      r_pol        <= 1'b0;
      r_dur        <= '0;
      r_gap        <= '0;
      r_note_ready <= 1'b1;
      r_busy       <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_cmd_accept) begin
            r_state      <= S_PLAY;
            r_phase      <= '0;
            r_pol        <= 1'b0;
            r_half       <= w_half_in;
            r_dur        <= w_dur_load;
            r_sample     <= (w_half_in == 7'd0) ? 24'd0 : AMPL;
            r_note_ready <= 1'b0;
            r_busy       <= 1'b1;
          end
        end

        S_PLAY: begin
          if (w_accept) begin
            r_dur <= r_dur - DUR_W'(1);
            if (r_dur == DUR_W'(1)) begin
              r_state  <= S_GAP;
              r_gap    <= GAP_W'(GAP_SAMPLES);
              r_sample <= '0;
            end else begin
              r_phase  <= w_wrap ? 7'd0 : r_phase + 7'd1;
              r_pol    <= w_pol_next;
              if (r_half == 7'd0) begin
                r_sample <= '0;
              end else begin
                r_sample <= w_pol_next ? AMPL_NEG : AMPL;
              end
            end
          end
        end

        S_GAP: begin
          if (w_accept) begin
            r_gap <= r_gap - GAP_W'(1);
            if (r_gap == GAP_W'(1)) begin
              r_state      <= S_IDLE;
              r_note_ready <= 1'b1;
              r_busy       <= 1'b0;
            end
          end
        end

        default: begin
          r_state      <= S_IDLE;
          r_sample     <= '0;
          r_note_ready <= 1'b1;
          r_busy       <= 1'b0;
        end
      endcase
    end
  end

endmodule
